// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_ctrl
//  Function : EX-stage branch sequencer. Waits for flags, drives the branch
//             unit, then issues a PC redirect followed by a front-end flush.
//  Revision : 1.0  initial release
// ============================================================================
module branch_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              br_valid_i,
   output logic              br_ready_o,
   input  logic [ADDR_W-1:0] br_pc_i,
   input  logic [2:0]        br_cc_i,
   input  logic [ADDR_W-1:0] br_src_i,
   input  logic              br_abs_i,
   input  logic [5:0]        flags_i,
   input  logic              flags_pending_i,
   input  logic              kill_i,
   output logic [ADDR_W-1:0] bu_pc_o,
   output logic [2:0]        bu_cc_o,
   output logic [5:0]        bu_flags_o,
   output logic [ADDR_W-1:0] bu_src_o,
   output logic              bu_abs_o,
   input  logic [ADDR_W-1:0] bu_dest_addr_i,
   input  logic              bu_branch_en_i,
   output logic              redirect_valid_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  taken_cnt_o,
   output logic [CNT_W-1:0]  not_taken_cnt_o
);

   localparam int c_FCNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_FLAGS = 3'd1,
      S_EVAL       = 3'd2,
      S_REDIRECT   = 3'd3,
      S_FLUSH      = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_src;
   logic [2:0]          r_cc;
   logic                r_abs;
   logic [5:0]          r_flags;
   logic [ADDR_W-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]    r_taken_cnt;
   logic [CNT_W-1:0]    r_not_taken_cnt;
   logic [c_FCNT_W-1:0] r_fcnt;

   logic w_accept;
   logic w_capture;
   logic w_taken;
   logic w_not_taken;

   // kill_i overrides every transition and suppresses all side effects
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_taken     = 1'b0;
      w_not_taken = 1'b0;
      if (kill_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (br_valid_i) begin
                  w_accept = 1'b1;
                  if ((br_cc_i == 3'b000) || !flags_pending_i) begin
                     w_capture   = 1'b1;
                     w_state_nxt = S_EVAL;
                  end else begin
                     w_state_nxt = S_WAIT_FLAGS;
                  end
               end
            end
            S_WAIT_FLAGS: begin
               if (!flags_pending_i) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_EVAL;
               end
            end
            S_EVAL: begin
               if (bu_branch_en_i) begin
                  w_taken     = 1'b1;
                  w_state_nxt = S_REDIRECT;
               end else begin
                  w_not_taken = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_REDIRECT: w_state_nxt = S_FLUSH;
            S_FLUSH: begin
               if (r_fcnt <= c_FCNT_W'(1)) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state         <= S_IDLE;
         r_pc            <= '0;
         r_src           <= '0;
         r_cc            <= '0;
         r_abs           <= 1'b0;
         r_flags         <= '0;
         r_redirect_pc   <= '0;
         r_taken_cnt     <= '0;
         r_not_taken_cnt <= '0;
         r_fcnt          <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_pc  <= br_pc_i;
            r_src <= br_src_i;
            r_cc  <= br_cc_i;
            r_abs <= br_abs_i;
         end
         if (w_capture) begin
            r_flags <= flags_i;
         end
         if (w_taken) begin
            r_redirect_pc <= bu_dest_addr_i;
            r_taken_cnt   <= r_taken_cnt + CNT_W'(1);
         end
         if (w_not_taken) begin
            r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
         end
         if (r_state == S_REDIRECT) begin
            r_fcnt <= c_FCNT_W'(FLUSH_CYCLES);
         end else if (r_state == S_FLUSH) begin
            r_fcnt <= r_fcnt - c_FCNT_W'(1);
         end
      end
   end

   assign br_ready_o       = (r_state == S_IDLE);
   assign stall_o          = (r_state != S_IDLE);
   assign redirect_valid_o = (r_state == S_REDIRECT) && !kill_i;
   assign flush_o          = (r_state == S_REDIRECT) || (r_state == S_FLUSH);
   assign redirect_pc_o    = r_redirect_pc;
   assign taken_cnt_o      = r_taken_cnt;
   assign not_taken_cnt_o  = r_not_taken_cnt;

   assign bu_pc_o    = r_pc;
   assign bu_cc_o    = r_cc;
   assign bu_flags_o = r_flags;
   assign bu_src_o   = r_src;
   assign bu_abs_o   = r_abs;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_ctrl
//  Function : Directed self-checking bench for branch_ctrl with a branch unit
//             model attached to the bu_* interface.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

   localparam int ADDR_W       = 32;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 4;

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic              br_valid_i;
   logic              br_ready_o;
   logic [ADDR_W-1:0] br_pc_i;
   logic [2:0]        br_cc_i;
   logic [ADDR_W-1:0] br_src_i;
   logic              br_abs_i;
   logic [5:0]        flags_i;
   logic              flags_pending_i;
   logic              kill_i;
   logic [ADDR_W-1:0] bu_pc_o;
   logic [2:0]        bu_cc_o;
   logic [5:0]        bu_flags_o;
   logic [ADDR_W-1:0] bu_src_o;
   logic              bu_abs_o;
   logic [ADDR_W-1:0] bu_dest_addr_i;
   logic              bu_branch_en_i;
   logic              redirect_valid_o;
   logic [ADDR_W-1:0] redirect_pc_o;
   logic              flush_o;
   logic              stall_o;
   logic [CNT_W-1:0]  taken_cnt_o;
   logic [CNT_W-1:0]  not_taken_cnt_o;

   int n_checks = 0;
   int n_errors = 0;
   int exp_taken = 0;
   int exp_ntaken = 0;

   always #5 clk_i = ~clk_i;

   branch_ctrl #(
      .ADDR_W      (ADDR_W),
      .FLUSH_CYCLES(FLUSH_CYCLES),
      .CNT_W       (CNT_W)
   ) u_dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .br_valid_i      (br_valid_i),
      .br_ready_o      (br_ready_o),
      .br_pc_i         (br_pc_i),
      .br_cc_i         (br_cc_i),
      .br_src_i        (br_src_i),
      .br_abs_i        (br_abs_i),
      .flags_i         (flags_i),
      .flags_pending_i (flags_pending_i),
      .kill_i          (kill_i),
      .bu_pc_o         (bu_pc_o),
      .bu_cc_o         (bu_cc_o),
      .bu_flags_o      (bu_flags_o),
      .bu_src_o        (bu_src_o),
      .bu_abs_o        (bu_abs_o),
      .bu_dest_addr_i  (bu_dest_addr_i),
      .bu_branch_en_i  (bu_branch_en_i),
      .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o   (redirect_pc_o),
      .flush_o         (flush_o),
      .stall_o         (stall_o),
      .taken_cnt_o     (taken_cnt_o),
      .not_taken_cnt_o (not_taken_cnt_o)
   );

   // Combinational branch unit: flags {Z,P,N,C,V,rsvd}
   always_comb begin
      bu_dest_addr_i = bu_abs_o ? bu_src_o : (bu_pc_o + bu_src_o);
      case (bu_cc_o)
         3'b000:  bu_branch_en_i = 1'b1;
         3'b001:  bu_branch_en_i = bu_flags_o[5];
         3'b010:  bu_branch_en_i = bu_flags_o[4];
         3'b011:  bu_branch_en_i = bu_flags_o[3];
         3'b100:  bu_branch_en_i = bu_flags_o[2];
         3'b101:  bu_branch_en_i = bu_flags_o[1];
         default: bu_branch_en_i = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_counts();
      check("taken_cnt", 64'(taken_cnt_o), 64'(exp_taken % 16));
      check("not_taken_cnt", 64'(not_taken_cnt_o), 64'(exp_ntaken % 16));
   endtask

   task automatic drive_op(input logic [31:0] pc, input logic [2:0] cc,
                           input logic [31:0] src, input logic abs);
      br_valid_i = 1'b1;
      br_pc_i    = pc;
      br_cc_i    = cc;
      br_src_i   = src;
      br_abs_i   = abs;
   endtask

   task automatic release_op();
      br_valid_i = 1'b0;
      br_pc_i    = ~br_pc_i;
      br_src_i   = ~br_src_i;
      br_cc_i    = ~br_cc_i;
      br_abs_i   = ~br_abs_i;
   endtask

   // Full branch with pend cycles of flags_pending_i starting at the accept cycle
   task automatic run_branch(input logic [31:0] pc, input logic [2:0] cc,
                             input logic [31:0] src, input logic abs,
                             input logic [5:0] flags, input int pend,
                             input bit exp_tk, input logic [31:0] exp_dest);
      check("ready_at_accept", br_ready_o, 1);
      drive_op(pc, cc, src, abs);
      flags_pending_i = (pend > 0);
      flags_i         = (pend > 0) ? ~flags : flags;
      step();
      release_op();
      for (int i = 1; i < pend; i++) begin
         check("wait_stall", stall_o, 1);
         check("wait_ready", br_ready_o, 0);
         step();
      end
      if (pend > 0) begin
         flags_pending_i = 1'b0;
         flags_i         = flags;
         check("wait_last_stall", stall_o, 1);
         step();
      end
      flags_i = ~flags;
      check("eval_stall", stall_o, 1);
      check("eval_bu_pc", bu_pc_o, pc);
      check("eval_bu_cc", bu_cc_o, cc);
      check("eval_bu_src", bu_src_o, src);
      check("eval_bu_abs", bu_abs_o, abs);
      check("eval_bu_flags", bu_flags_o, flags);
      check("eval_no_redirect", redirect_valid_o, 0);
      step();
      if (exp_tk) begin
         exp_taken++;
         check("redirect_valid", redirect_valid_o, 1);
         check("redirect_pc", redirect_pc_o, exp_dest);
         check("redirect_flush", flush_o, 1);
         step();
         for (int i = 0; i < FLUSH_CYCLES; i++) begin
            check("flush_high", flush_o, 1);
            check("flush_no_redirect", redirect_valid_o, 0);
            check("flush_ready", br_ready_o, 0);
            step();
         end
      end else begin
         exp_ntaken++;
      end
      check("done_ready", br_ready_o, 1);
      check("done_stall", stall_o, 0);
      check("done_flush", flush_o, 0);
      check("done_redirect", redirect_valid_o, 0);
      check_counts();
   endtask

   initial begin
      rst_n_i         = 1'b0;
      br_valid_i      = 1'b0;
      br_pc_i         = '0;
      br_cc_i         = '0;
      br_src_i        = '0;
      br_abs_i        = 1'b0;
      flags_i         = '0;
      flags_pending_i = 1'b0;
      kill_i          = 1'b0;
      #1;
      check("rst_ready", br_ready_o, 1);
      check("rst_stall", stall_o, 0);
      check("rst_flush", flush_o, 0);
      check("rst_redirect", redirect_valid_o, 0);
      check("rst_redirect_pc", redirect_pc_o, 0);
      check("rst_bu_pc", bu_pc_o, 0);
      check_counts();
      #16 rst_n_i = 1'b1;
      step();

      // Taken, relative, always
      run_branch(32'h100, 3'b000, 32'h20, 1'b0, 6'b000000, 0, 1'b1, 32'h120);
      // Z condition: clear then set
      run_branch(32'h200, 3'b001, 32'h40, 1'b0, 6'b000000, 0, 1'b0, 32'h0);
      run_branch(32'h300, 3'b001, 32'h40, 1'b0, 6'b100000, 0, 1'b1, 32'h340);
      // N condition behind 4 cycles of pending flags
      run_branch(32'h1000, 3'b011, 32'h80, 1'b0, 6'b001000, 4, 1'b1, 32'h1080);
      // Absolute target and relative wrap
      run_branch(32'hFFFFFFF0, 3'b000, 32'hDEADBEEC, 1'b1, 6'b000000, 0, 1'b1, 32'hDEADBEEC);
      run_branch(32'hFFFFFFF0, 3'b000, 32'h20, 1'b0, 6'b000000, 0, 1'b1, 32'h00000010);
      // Remaining condition codes and a reserved one
      run_branch(32'h500, 3'b010, 32'h4, 1'b0, 6'b010000, 0, 1'b1, 32'h504);
      run_branch(32'h40, 3'b100, 32'hFFFFFFF0, 1'b0, 6'b000100, 1, 1'b1, 32'h30);
      run_branch(32'h600, 3'b101, 32'h8, 1'b0, 6'b111101, 0, 1'b0, 32'h0);
      run_branch(32'h700, 3'b110, 32'h8, 1'b0, 6'b111111, 0, 1'b0, 32'h0);

      // Kill in EVAL of a taken branch
      drive_op(32'h900, 3'b000, 32'h4, 1'b0);
      step();
      release_op();
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      check("kill_eval_ready", br_ready_o, 1);
      check("kill_eval_redirect", redirect_valid_o, 0);
      check("kill_eval_flush", flush_o, 0);
      check_counts();
      step();
      check("kill_eval_still_idle", redirect_valid_o, 0);

      // Kill alongside br_valid_i in IDLE: no accept
      drive_op(32'hABC, 3'b001, 32'h10, 1'b1);
      kill_i = 1'b1;
      step();
      release_op();
      kill_i = 1'b0;
      check("kill_idle_ready", br_ready_o, 1);
      check("kill_idle_stall", stall_o, 0);
      check("kill_idle_bu_pc", bu_pc_o, 32'h900);

      // Kill during REDIRECT suppresses the pulse
      drive_op(32'h800, 3'b000, 32'h8, 1'b0);
      step();
      release_op();
      step();
      exp_taken++;
      check("kr_redirect_before", redirect_valid_o, 1);
      kill_i = 1'b1;
      #1;
      check("kr_redirect_killed", redirect_valid_o, 0);
      check("kr_redirect_pc", redirect_pc_o, 32'h808);
      step();
      kill_i = 1'b0;
      check("kr_ready", br_ready_o, 1);
      check("kr_flush", flush_o, 0);
      check_counts();

      // Reset asserted in FLUSH
      drive_op(32'h200, 3'b000, 32'h10, 1'b0);
      step();
      release_op();
      step();
      step();
      check("pre_rst_flush", flush_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      exp_taken  = 0;
      exp_ntaken = 0;
      check("mid_rst_ready", br_ready_o, 1);
      check("mid_rst_stall", stall_o, 0);
      check("mid_rst_flush", flush_o, 0);
      check("mid_rst_redirect", redirect_valid_o, 0);
      check("mid_rst_redirect_pc", redirect_pc_o, 0);
      check("mid_rst_bu_pc", bu_pc_o, 0);
      check_counts();
      #3 rst_n_i = 1'b1;
      step();
      check("post_rst_flush", flush_o, 0);
      check("post_rst_ready", br_ready_o, 1);

      // 2^CNT_W+1 taken branches wrap the counter to 1
      for (int i = 0; i < 17; i++) begin
         run_branch(32'h1000 + 32'(i * 16), 3'b000, 32'h4, 1'b0, 6'b000000, 0, 1'b1,
                    32'h1004 + 32'(i * 16));
      end
      check("wrap_taken_cnt", taken_cnt_o, 4'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
